// File: rtl/pseudo_lru_sets.sv
// pseudo_lru_sets: SETS independent tree-PLRU trees with per-way valid bits; invalid ways are victimised first.
// Optional PLRU_LOCK_EN: global lock_mask_i excludes ways from selection, repl_none_o flags "all locked".
module pseudo_lru_sets #(
  parameter int SETS = 16,
  parameter int WAYS = 8,
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             access_hit_i,
  input  logic [SET_W-1:0] access_set_i,
  input  logic [WAY_W-1:0] access_way_i,
  input  logic             fill_i,
  input  logic [SET_W-1:0] fill_set_i,
  input  logic [WAY_W-1:0] fill_way_i,
  input  logic             inv_i,
  input  logic [SET_W-1:0] inv_set_i,
  input  logic [WAY_W-1:0] inv_way_i,
  input  logic             repl_req_i,
  input  logic [SET_W-1:0] repl_set_i,
  output logic             repl_vld_o,
  output logic [WAY_W-1:0] repl_way_o
`ifdef PLRU_LOCK_EN
  ,
  input  logic [WAYS-1:0]  lock_mask_i,
  output logic             repl_none_o
`endif
);

  localparam int NODES = WAYS - 1;

  logic [NODES-1:0] tree_q  [SETS];
  logic [WAYS-1:0]  valid_q [SETS];

  // With a single set the index carries no information; pin it to 0.
  logic [SET_W-1:0] hit_set, fill_set, inv_set, repl_set;
  assign hit_set  = (SETS > 1) ? access_set_i : '0;
  assign fill_set = (SETS > 1) ? fill_set_i   : '0;
  assign inv_set  = (SETS > 1) ? inv_set_i    : '0;
  assign repl_set = (SETS > 1) ? repl_set_i   : '0;

  // Point every node on the way's root-to-leaf path away from that way.
  function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t,
                                             input logic [WAY_W-1:0] w);
    logic [NODES-1:0] r;
    int node;
    r    = t;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      r[node] = ~w[WAY_W-1-l];
      node    = 2 * node + 1 + int'(w[WAY_W-1-l]);
    end
    return r;
  endfunction

  logic hit_blocked;
  assign hit_blocked = fill_i && (fill_set == hit_set);

  // NOTE: sequential state is written only with non-blocking assignments so every
  // read in this block sees the pre-edge value, regardless of statement order.
  // NOTE: the tree/valid arrays are ordinary flops (not a RAM macro), so they take
  // the asynchronous reset like any other register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < SETS; s++) begin
        tree_q[s]  <= '0;
        valid_q[s] <= '0;
      end
    end else if (flush_i) begin
      for (int s = 0; s < SETS; s++) begin
        tree_q[s]  <= '0;
        valid_q[s] <= '0;
      end
    end else begin
      if (access_hit_i && !hit_blocked)
        tree_q[hit_set] <= touch(tree_q[hit_set], access_way_i);
      if (fill_i)
        tree_q[fill_set] <= touch(tree_q[fill_set], fill_way_i);
      if (inv_i)
        valid_q[inv_set][inv_way_i] <= 1'b0;
      // Last assignment wins, so a same-way fill overrides the invalidate.
      if (fill_i)
        valid_q[fill_set][fill_way_i] <= 1'b1;
    end
  end

  logic [NODES-1:0] sel_tree;
  logic [WAYS-1:0]  sel_valid;
  logic [WAYS-1:0]  usable;
  logic [WAY_W-1:0] victim_way;

  assign sel_tree  = tree_q[repl_set];
  assign sel_valid = valid_q[repl_set];
`ifdef PLRU_LOCK_EN
  assign usable = ~lock_mask_i;
`else
  assign usable = '1;
`endif

  // NOTE: every variable driven here receives a default before any conditional
  // assignment, so no path can leave it holding state (no latch).
  always_comb begin
    int  node;
    int  base;
    int  size;
    logic found;
    logic go_up;
    logic lo_free;
    logic hi_free;
    victim_way = '0;
    found      = 1'b0;
    node       = 0;
    base       = 0;
    size       = WAYS;
    go_up      = 1'b0;
    lo_free    = 1'b0;
    hi_free    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !sel_valid[w] && usable[w]) begin
        found      = 1'b1;
        victim_way = WAY_W'(w);
      end
    end
    if (!found) begin
      for (int l = 0; l < WAY_W; l++) begin
        size    = size / 2;
        lo_free = 1'b0;
        hi_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          if (w >= base && w < base + size)
            lo_free = lo_free | usable[w];
          if (w >= base + size && w < base + 2 * size)
            hi_free = hi_free | usable[w];
        end
        // Follow the pointer unless the pointed subtree is entirely locked.
        go_up = sel_tree[node];
        if (go_up && !hi_free)
          go_up = 1'b0;
        else if (!go_up && !lo_free)
          go_up = 1'b1;
        if (go_up)
          base = base + size;
        node = 2 * node + 1 + int'(go_up);
      end
      victim_way = WAY_W'(base);
    end
`ifdef PLRU_LOCK_EN
    if (!(|usable))
      victim_way = '0;
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      repl_vld_o <= 1'b0;
      repl_way_o <= '0;
    end else begin
      repl_vld_o <= repl_req_i;
      if (repl_req_i)
        repl_way_o <= victim_way;
    end
  end

`ifdef PLRU_LOCK_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      repl_none_o <= 1'b0;
    else if (repl_req_i)
      repl_none_o <= ~(|usable);
  end
`endif

endmodule

// File: tb/tb_pseudo_lru_sets.sv
// tb_pseudo_lru_sets: directed scenarios plus randomized traffic against a behavioural PLRU model.
// Lock-mask scenarios are compiled in when PLRU_LOCK_EN is defined.
module tb_pseudo_lru_sets;

  localparam int SETS  = 16;
  localparam int WAYS  = 8;
  localparam int SET_W = 4;
  localparam int WAY_W = 3;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic             flush_i;
  logic             access_hit_i;
  logic [SET_W-1:0] access_set_i;
  logic [WAY_W-1:0] access_way_i;
  logic             fill_i;
  logic [SET_W-1:0] fill_set_i;
  logic [WAY_W-1:0] fill_way_i;
  logic             inv_i;
  logic [SET_W-1:0] inv_set_i;
  logic [WAY_W-1:0] inv_way_i;
  logic             repl_req_i;
  logic [SET_W-1:0] repl_set_i;
  logic             repl_vld_o;
  logic [WAY_W-1:0] repl_way_o;
`ifdef PLRU_LOCK_EN
  logic [WAYS-1:0]  lock_mask_i;
  logic             repl_none_o;
  bit               exp_none;
`endif

  int passed = 0;
  int total  = 0;
  int exp_way = 0;

  // Reference state: per-node "go to upper half" flags and per-way valid flags.
  bit m_tree  [SETS][WAYS-1];
  bit m_valid [SETS][WAYS];

  pseudo_lru_sets #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .flush_i      (flush_i),
    .access_hit_i (access_hit_i),
    .access_set_i (access_set_i),
    .access_way_i (access_way_i),
    .fill_i       (fill_i),
    .fill_set_i   (fill_set_i),
    .fill_way_i   (fill_way_i),
    .inv_i        (inv_i),
    .inv_set_i    (inv_set_i),
    .inv_way_i    (inv_way_i),
    .repl_req_i   (repl_req_i),
    .repl_set_i   (repl_set_i),
    .repl_vld_o   (repl_vld_o),
    .repl_way_o   (repl_way_o)
`ifdef PLRU_LOCK_EN
    , .lock_mask_i (lock_mask_i)
    , .repl_none_o (repl_none_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int n = 0; n < WAYS - 1; n++) m_tree[s][n] = 1'b0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  // Node at depth l on way w's path is (2^l - 1) + (w >> (depth-l)); it must point to the other half.
  task automatic m_touch(input int s, input int w);
    for (int l = 0; l < WAY_W; l++)
      m_tree[s][(1 << l) - 1 + (w >> (WAY_W - l))] = !((w >> (WAY_W - 1 - l)) & 1);
  endtask

  function automatic bit all_locked(input bit [WAYS-1:0] lk, input int lo, input int n);
    for (int i = lo; i < lo + n; i++)
      if (!lk[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_pick(input int s, input bit [WAYS-1:0] lk);
    int lo;
    int size;
    int lvl;
    bit up;
    if (&lk) return 0;
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w] && !lk[w]) return w;
    lo   = 0;
    size = WAYS;
    lvl  = 0;
    while (size > 1) begin
      up = m_tree[s][(1 << lvl) - 1 + lo / size];
      if (up && all_locked(lk, lo + size / 2, size / 2)) up = 1'b0;
      else if (!up && all_locked(lk, lo, size / 2)) up = 1'b1;
      if (up) lo = lo + size / 2;
      size = size / 2;
      lvl++;
    end
    return lo;
  endfunction

  task automatic clear_inputs();
    flush_i = 0; access_hit_i = 0; access_set_i = '0; access_way_i = '0;
    fill_i = 0; fill_set_i = '0; fill_way_i = '0;
    inv_i = 0; inv_set_i = '0; inv_way_i = '0;
    repl_req_i = 0; repl_set_i = '0;
`ifdef PLRU_LOCK_EN
    lock_mask_i = '0;
`endif
  endtask

  // Predict from the pre-edge model, advance the model, clock once, compare.
  task automatic cycle();
    bit [WAYS-1:0] lk;
    bit exp_vld;
    lk = '0;
`ifdef PLRU_LOCK_EN
    lk = lock_mask_i;
`endif
    exp_vld = repl_req_i;
    if (repl_req_i) begin
      exp_way = m_pick(int'(repl_set_i), lk);
`ifdef PLRU_LOCK_EN
      exp_none = &lk;
`endif
    end
    if (flush_i) m_reset();
    else begin
      if (inv_i) m_valid[inv_set_i][inv_way_i] = 1'b0;
      if (fill_i) begin
        m_valid[fill_set_i][fill_way_i] = 1'b1;
        m_touch(int'(fill_set_i), int'(fill_way_i));
      end
      if (access_hit_i && !(fill_i && fill_set_i == access_set_i))
        m_touch(int'(access_set_i), int'(access_way_i));
    end
    @(posedge clk_i);
    #1;
    check("repl_vld", {31'd0, repl_vld_o}, {31'd0, exp_vld});
    if (exp_vld) check("repl_way", {29'd0, repl_way_o}, exp_way);
`ifdef PLRU_LOCK_EN
    if (exp_vld) check("repl_none", {31'd0, repl_none_o}, {31'd0, exp_none});
`endif
    clear_inputs();
  endtask

  task automatic do_fill(input int s, input int w);
    fill_i = 1; fill_set_i = SET_W'(s); fill_way_i = WAY_W'(w);
    cycle();
  endtask

  task automatic do_hit(input int s, input int w);
    access_hit_i = 1; access_set_i = SET_W'(s); access_way_i = WAY_W'(w);
    cycle();
  endtask

  task automatic do_req(input int s);
    repl_req_i = 1; repl_set_i = SET_W'(s);
    cycle();
  endtask

  initial begin
    clear_inputs();
    m_reset();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_vld", {31'd0, repl_vld_o}, 0);
    check("reset_way", {29'd0, repl_way_o}, 0);
    rstn_i = 1'b1;

    do_req(3);
    check("empty_set_way0", {29'd0, repl_way_o}, 0);
    for (int w = 0; w < WAYS; w++) do_fill(3, w);
    do_req(3);
    check("filled_in_order_way0", {29'd0, repl_way_o}, 0);
    do_hit(3, 0);
    do_req(3);
    check("after_hit0_way4", {29'd0, repl_way_o}, 4);
    do_hit(3, 4);
    do_req(3);
    check("after_hit4_way2", {29'd0, repl_way_o}, 2);

    do_inv(3, 5);
    check("inv5_way5", {29'd0, repl_way_o}, 5);
    fill_i = 1; fill_set_i = 3; fill_way_i = 5;
    repl_req_i = 1; repl_set_i = 3;
    cycle();
    check("fill_same_cycle_way5", {29'd0, repl_way_o}, 5);

    for (int w = 0; w < WAYS; w++) do_fill(2, w);
    access_hit_i = 1; access_set_i = 2; access_way_i = 1;
    fill_i = 1; fill_set_i = 2; fill_way_i = 6;
    cycle();
    do_req(2);
    check("hit_fill_same_set", {29'd0, repl_way_o}, 0);
    do_req(1);
    check("set1_untouched", {29'd0, repl_way_o}, 0);

    do_hit(3, 5);
    do_hit(3, 7);
    do_hit(3, 0);
    do_req(3);
    check("pre_flush_way4", {29'd0, repl_way_o}, 4);
    flush_i = 1; repl_req_i = 1; repl_set_i = 3;
    cycle();
    check("flush_cycle_way4", {29'd0, repl_way_o}, 4);
    do_req(3);
    check("post_flush_way0", {29'd0, repl_way_o}, 0);

    do_fill(3, 0);
    do_req(3);
    check("one_valid_way1", {29'd0, repl_way_o}, 1);
    repl_req_i = 1; repl_set_i = 3;
    #2 rstn_i = 1'b0;
    #1;
    check("async_rst_vld", {31'd0, repl_vld_o}, 0);
    check("async_rst_way", {29'd0, repl_way_o}, 0);
    @(negedge clk_i);
    clear_inputs();
    m_reset();
    exp_way = 0;
    rstn_i = 1'b1;
    cycle();
    do_req(3);
    check("after_rst_way0", {29'd0, repl_way_o}, 0);

`ifdef PLRU_LOCK_EN
    for (int w = 0; w < WAYS; w++) do_fill(3, w);
    do_hit(3, 3);
    do_req(3);
    check("lock_pre_way4", {29'd0, repl_way_o}, 4);
    lock_mask_i = 8'hF0; repl_req_i = 1; repl_set_i = 3;
    cycle();
    check("lock_f0_way0", {29'd0, repl_way_o}, 0);
    lock_mask_i = 8'hFF; repl_req_i = 1; repl_set_i = 3;
    cycle();
    check("lock_ff_none", {31'd0, repl_none_o}, 1);
    check("lock_ff_way0", {29'd0, repl_way_o}, 0);
`endif

    // Random traffic concentrated on a few sets so same-set collisions are frequent.
    for (int i = 0; i < 400; i++) begin
      access_hit_i = ($urandom_range(0, 2) == 0);
      access_set_i = SET_W'($urandom_range(0, 3));
      access_way_i = WAY_W'($urandom_range(0, WAYS - 1));
      fill_i       = ($urandom_range(0, 1) == 0);
      fill_set_i   = SET_W'($urandom_range(0, 3));
      fill_way_i   = WAY_W'($urandom_range(0, WAYS - 1));
      inv_i        = ($urandom_range(0, 4) == 0);
      inv_set_i    = SET_W'($urandom_range(0, 3));
      inv_way_i    = WAY_W'($urandom_range(0, WAYS - 1));
      repl_req_i   = ($urandom_range(0, 1) == 0);
      repl_set_i   = SET_W'($urandom_range(0, 3));
      flush_i      = ($urandom_range(0, 63) == 0);
`ifdef PLRU_LOCK_EN
      lock_mask_i  = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : '0;
`endif
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  task automatic do_inv(input int s, input int w);
    inv_i = 1; inv_set_i = SET_W'(s); inv_way_i = WAY_W'(w);
    cycle();
    do_req(s);
  endtask

endmodule
